// File: rtl/jt12_kon_pkg.sv
// jt12 key-on scheduler shared constants: FSM encoding, command bundle,
// FIFO/timeout defaults and the invalid-channel test.
package jt12_kon_pkg;

    typedef enum logic [1:0] {
        KS_IDLE  = 2'd0,
        KS_ISSUE = 2'd1,
        KS_WAIT  = 2'd2
    } kon_state_e;

    localparam int KON_DEPTH = 4;
    localparam int KON_TMO   = 31;
    localparam int KON_W     = 7;

    typedef struct packed {
        logic [3:0] op;
        logic [2:0] ch;
    } kon_cmd_t;

    // Channel codes 3 and 7 do not address a real channel.
    function automatic logic ch_invalid(input logic [2:0] ch);
        return ch[1:0] == 2'b11;
    endfunction

endpackage

// File: rtl/jt12_kon_fifo.sv
// In-order key-on command FIFO, DEPTH entries (power of 2).
// Ports: clk_i, rst_i (async high), push_i, pop_i, din_i -> dout_o (head),
//        full_o, empty_o, cnt_o (occupancy). Push on full succeeds only with pop.
module jt12_kon_fifo
    import jt12_kon_pkg::*;
#(
    parameter int DEPTH = KON_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [KON_W-1:0]         din_i,
    output logic [KON_W-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   cnt_o
);

    localparam int AW = $clog2(DEPTH);

    logic [KON_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wp_q, wp_d;
    logic [AW-1:0]    rp_q, rp_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign cnt_o   = cnt_q;
    assign dout_o  = mem_q[rp_q];

    always_comb begin
        do_pop  = pop_i & ~empty_o;
        do_push = push_i & (~full_o | do_pop);
        wp_d    = wp_q + AW'(do_push);
        rp_d    = rp_q + AW'(do_pop);
        cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wp_q] <= din_i;
        end
    end

endmodule

// File: rtl/jt12_kon_sched.sv
// jt12 key-on scheduler: captures host key-on writes, queues them and
// issues one up_keyon strobe per command, waiting for the slot sequencer.
// Inputs : clk_i, rst_i (async high), clk_en_i, wr_i, din_i[7:0]
//          ({op mask, -, ch}), next_op_i, next_ch_i, clr_err_i.
// Outputs: up_keyon_o, keyon_op_o, keyon_ch_o, busy_o, full_o,
//          ovf_err_o (lost write), tmo_err_o (sequencer never matched).
module jt12_kon_sched
    import jt12_kon_pkg::*;
#(
    parameter int DEPTH = KON_DEPTH,
    parameter int TMO   = KON_TMO
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clk_en_i,
    input  logic       wr_i,
    input  logic [7:0] din_i,
    input  logic [1:0] next_op_i,
    input  logic [2:0] next_ch_i,
    input  logic       clr_err_i,
    output logic       up_keyon_o,
    output logic [3:0] keyon_op_o,
    output logic [2:0] keyon_ch_o,
    output logic       busy_o,
    output logic       full_o,
    output logic       ovf_err_o,
    output logic       tmo_err_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(TMO + 1);

    // Capture register
    kon_cmd_t cap_q, cap_d;
    logic     cap_vld_q, cap_vld_d;
    logic     push_evt, push_req, cap_ovf;
    logic     unused_din;

    assign unused_din = din_i[3];

    // Capture runs on every clk so a host strobe is never missed;
    // it drains into the FIFO on the next enabled cycle.
    always_comb begin
        push_evt  = clk_en_i & cap_vld_q;
        push_req  = push_evt & ~ch_invalid(cap_q.ch);
        cap_ovf   = wr_i & cap_vld_q & ~push_evt;
        cap_vld_d = wr_i | (cap_vld_q & ~push_evt);
        cap_d     = cap_q;
        if (wr_i) begin
            cap_d.op = din_i[7:4];
            cap_d.ch = din_i[2:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cap_vld_q <= 1'b0;
            cap_q     <= '0;
        end else begin
            cap_vld_q <= cap_vld_d;
            cap_q     <= cap_d;
        end
    end

    // Command FIFO
    logic [KON_W-1:0] head;
    kon_cmd_t         head_cmd;
    logic             fifo_full, fifo_empty, pop;
    logic [CW-1:0]    fifo_cnt_unused;

    jt12_kon_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push_req),
        .pop_i   (pop),
        .din_i   (cap_q),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .cnt_o   (fifo_cnt_unused)
    );

    assign head_cmd = kon_cmd_t'(head);

    // Issue FSM
    kon_state_e    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          up_keyon_q, up_keyon_d;
    logic [3:0]    op_q, op_d;
    logic [2:0]    ch_q, ch_d;
    logic          match, tmo_hit, tmo_set, ovf_set;
    logic          ovf_q, ovf_d, tmo_q, tmo_d;

    assign match   = (next_ch_i == ch_q) && (next_op_i == 2'd3);
    assign tmo_hit = (timer_q == TW'(TMO));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= KS_IDLE;
        end else if (clk_en_i) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (1'b1)
            (state_q == KS_IDLE): begin
                if (!fifo_empty) state_d = KS_ISSUE;
            end
            (state_q == KS_ISSUE): begin
                state_d = KS_WAIT;
            end
            (state_q == KS_WAIT): begin
                if (match || tmo_hit) state_d = KS_IDLE;
            end
            default: begin
                state_d = KS_IDLE;
            end
        endcase
    end

    always_comb begin
        pop     = 1'b0;
        timer_d = timer_q;
        tmo_set = 1'b0;
        op_d    = op_q;
        ch_d    = ch_q;
        unique case (1'b1)
            (state_q == KS_IDLE): begin
                timer_d = '0;
                if (!fifo_empty) begin
                    pop  = clk_en_i;
                    op_d = head_cmd.op;
                    ch_d = head_cmd.ch;
                end
            end
            (state_q == KS_ISSUE): begin
                timer_d = '0;
            end
            (state_q == KS_WAIT): begin
                timer_d = timer_q + 1'b1;
                tmo_set = clk_en_i & ~match & tmo_hit;
            end
            default: begin
                timer_d = '0;
            end
        endcase
        // Strobe is registered so it is high for exactly the ISSUE cycle.
        up_keyon_d = (state_d == KS_ISSUE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            timer_q    <= '0;
            up_keyon_q <= 1'b0;
            op_q       <= '0;
            ch_q       <= '0;
        end else if (clk_en_i) begin
            timer_q    <= timer_d;
            up_keyon_q <= up_keyon_d;
            op_q       <= op_d;
            ch_q       <= ch_d;
        end
    end

    // Sticky errors: a new event wins over a clear in the same cycle.
    always_comb begin
        ovf_set = cap_ovf | (push_req & fifo_full & ~pop);
        ovf_d   = ovf_set | (ovf_q & ~(clk_en_i & clr_err_i));
        tmo_d   = tmo_set | (tmo_q & ~(clk_en_i & clr_err_i));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf_q <= 1'b0;
            tmo_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            tmo_q <= tmo_d;
        end
    end

    assign up_keyon_o = up_keyon_q;
    assign keyon_op_o = op_q;
    assign keyon_ch_o = ch_q;
    assign busy_o     = ~fifo_empty | (state_q != KS_IDLE);
    assign full_o     = fifo_full;
    assign ovf_err_o  = ovf_q;
    assign tmo_err_o  = tmo_q;

endmodule

// File: tb/tb_jt12_kon_sched.sv
// Directed bench for jt12_kon_sched: single write, invalid channels,
// overflow ordering, full push+pop, timeout and mid-WAIT reset.
module tb_jt12_kon_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_en = 1'b1;
    logic       wr = 1'b0;
    logic [7:0] din = 8'h00;
    logic [1:0] next_op = 2'd0;
    logic [2:0] next_ch = 3'd0;
    logic       clr_err = 1'b0;
    logic       up_keyon;
    logic [3:0] keyon_op;
    logic [2:0] keyon_ch;
    logic       busy, full, ovf_err, tmo_err;

    int n_chk = 0;
    int n_err = 0;

    logic       seq_run = 1'b0;
    logic [4:0] seq_cnt = 5'd0;
    logic [7:0] stb_q[$];
    int         since = 1000;
    int         min_gap = 1000;

    jt12_kon_sched dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .clk_en_i   (clk_en),
        .wr_i       (wr),
        .din_i      (din),
        .next_op_i  (next_op),
        .next_ch_i  (next_ch),
        .clr_err_i  (clr_err),
        .up_keyon_o (up_keyon),
        .keyon_op_o (keyon_op),
        .keyon_ch_o (keyon_ch),
        .busy_o     (busy),
        .full_o     (full),
        .ovf_err_o  (ovf_err),
        .tmo_err_o  (tmo_err)
    );

    initial forever #5 clk = ~clk;

    // Free-running slot sequencer: {ch, op} counts through all 32 slots.
    initial forever begin
        @(negedge clk);
        if (seq_run) begin
            next_ch = seq_cnt[4:2];
            next_op = seq_cnt[1:0];
            seq_cnt = seq_cnt + 5'd1;
        end
    end

    // Strobe log as {op, 0, ch} plus minimum spacing between strobes.
    initial forever begin
        @(negedge clk);
        since = since + 1;
        if (up_keyon === 1'b1) begin
            stb_q.push_back({keyon_op, 1'b0, keyon_ch});
            if (since < min_gap) min_gap = since;
            since = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr_one(input logic [7:0] b);
        @(negedge clk);
        wr = 1'b1;
        din = b;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic seq_go(input logic [4:0] start);
        @(negedge clk);
        seq_cnt = start;
        seq_run = 1'b1;
    endtask

    task automatic seq_stop();
        @(negedge clk);
        seq_run = 1'b0;
        next_ch = 3'd0;
        next_op = 2'd0;
    endtask

    task automatic wait_stb(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (stb_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, stb_q.size(), n);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, busy, 1'b0);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    logic [7:0] v4 [5];
    logic [7:0] e5 [6];
    logic [7:0] f4 [4];

    initial begin
        // Reset state
        cyc(3);
        chk("rst_stb", up_keyon, 1'b0);
        chk("rst_op", keyon_op, 4'h0);
        chk("rst_ch", keyon_ch, 3'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_full", full, 1'b0);
        chk("rst_ovf", ovf_err, 1'b0);
        chk("rst_tmo", tmo_err, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        cyc(2);

        // Single command with a running sequencer
        seq_go(5'd0);
        stb_q.delete();
        wr_one(8'hF1);
        wait_stb("single_cnt", 1, 100);
        chk("single_val", stb_q[0], 8'hF1);
        wait_idle("single_idle", 100);
        chk("single_op_hold", keyon_op, 4'hF);
        chk("single_ch_hold", keyon_ch, 3'h1);
        cyc(40);
        chk("single_only1", stb_q.size(), 1);

        // Invalid channels are silently dropped
        stb_q.delete();
        wr_one(8'hF3);
        wr_one(8'hF7);
        cyc(40);
        chk("inv_stb", stb_q.size(), 0);
        chk("inv_busy", busy, 1'b0);
        chk("inv_ovf", ovf_err, 1'b0);
        chk("inv_tmo", tmo_err, 1'b0);

        // Overflow: one command parked in WAIT, then five back-to-back
        seq_stop();
        stb_q.delete();
        wr_one(8'h36);
        cyc(5);
        v4 = '{8'h10, 8'h21, 8'h42, 8'h84, 8'hF5};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            wr = 1'b1;
            din = v4[i];
        end
        @(negedge clk);
        wr = 1'b0;
        cyc(3);
        chk("ovf_full", full, 1'b1);
        chk("ovf_flag", ovf_err, 1'b1);
        chk("ovf_busy", busy, 1'b1);
        seq_go(5'd24);
        wait_stb("ovf_cnt", 5, 400);
        e5 = '{8'h36, 8'h10, 8'h21, 8'h42, 8'h84, 8'h00};
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("ovf_ord%0d", i), stb_q[i], e5[i]);
        end
        wait_idle("ovf_idle", 100);
        chk("ovf_no_tmo", tmo_err, 1'b0);
        pulse_clr();
        chk("ovf_clr", ovf_err, 1'b0);

        // Full FIFO: push lands in the same cycle as a pop
        seq_stop();
        stb_q.delete();
        wr_one(8'h12);
        cyc(4);
        f4 = '{8'h20, 8'h41, 8'h84, 8'h85};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            wr = 1'b1;
            din = f4[i];
        end
        @(negedge clk);
        wr = 1'b0;
        cyc(3);
        chk("pp_full_pre", full, 1'b1);
        chk("pp_ovf_pre", ovf_err, 1'b0);
        @(negedge clk);
        next_ch = 3'd2;
        next_op = 2'd3;
        wr = 1'b1;
        din = 8'hF6;
        @(negedge clk);
        wr = 1'b0;
        next_ch = 3'd0;
        next_op = 2'd0;
        cyc(2);
        chk("pp_ovf", ovf_err, 1'b0);
        chk("pp_full", full, 1'b1);
        seq_go(5'd0);
        wait_stb("pp_cnt", 6, 500);
        e5 = '{8'h12, 8'h20, 8'h41, 8'h84, 8'h85, 8'hF6};
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("pp_ord%0d", i), stb_q[i], e5[i]);
        end
        wait_idle("pp_idle", 100);
        chk("pp_no_tmo", tmo_err, 1'b0);

        // Timeout with the sequencer frozen on channel 0
        seq_stop();
        stb_q.delete();
        wr_one(8'h22);
        cyc(24);
        chk("tmo_early", tmo_err, 1'b0);
        chk("tmo_busy", busy, 1'b1);
        cyc(24);
        chk("tmo_set", tmo_err, 1'b1);
        chk("tmo_idle", busy, 1'b0);
        chk("tmo_stb", stb_q.size(), 1);
        chk("tmo_val", stb_q[0], 8'h22);
        pulse_clr();
        chk("tmo_clr", tmo_err, 1'b0);

        // Reset mid-WAIT with two commands queued
        stb_q.delete();
        f4 = '{8'h30, 8'h31, 8'h32, 8'h00};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            wr = 1'b1;
            din = f4[i];
        end
        @(negedge clk);
        wr = 1'b0;
        cyc(5);
        chk("mid_busy_pre", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_stb", up_keyon, 1'b0);
        chk("mid_op", keyon_op, 4'h0);
        chk("mid_ch", keyon_ch, 3'h0);
        chk("mid_busy", busy, 1'b0);
        chk("mid_full", full, 1'b0);
        chk("mid_err", {ovf_err, tmo_err}, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        stb_q.delete();
        seq_go(5'd0);
        cyc(80);
        chk("mid_no_stb", stb_q.size(), 0);
        chk("mid_idle", busy, 1'b0);

        chk("gap_min3", min_gap >= 3, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
